// File: rtl/lcd_seq_pkg.sv
// Shared types and constants for the LCD sequencing controller: FSM state
// encoding, command codes, ROM layout and command classification helpers.
`timescale 1ns/1ps
package lcd_seq_pkg;

  localparam int IMG_PIX  = 64;
  localparam int CMD_BASE = 64;
  localparam int ROM_LAST = 127;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FETCH = 3'd2,
    ST_ISSUE = 3'd3,
    ST_WRITE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  localparam logic [3:0] SHIFT_UP      = 4'd1;
  localparam logic [3:0] SHIFT_DOWN    = 4'd2;
  localparam logic [3:0] SHIFT_LEFT    = 4'd3;
  localparam logic [3:0] SHIFT_RIGHT   = 4'd4;
  localparam logic [3:0] MIRROR_H      = 4'd5;
  localparam logic [3:0] MIRROR_V      = 4'd6;
  localparam logic [3:0] INVERT        = 4'd7;
  localparam logic [3:0] WRITE         = 4'd8;
  localparam logic [3:0] ROT_CW        = 4'd9;
  localparam logic [3:0] ROT_CCW       = 4'd10;
  localparam logic [3:0] BRIGHT_UP     = 4'd11;
  localparam logic [3:0] BRIGHT_DOWN   = 4'd12;
  localparam logic [3:0] THRESHOLD     = 4'd13;
  localparam logic [3:0] INV_THRESHOLD = 4'd14;

  // Codes 0 and anything above INV_THRESHOLD carry no operation.
  function automatic logic is_nop(input logic [7:0] code);
    return (code == 8'd0) || (code > {4'd0, INV_THRESHOLD});
  endfunction

  // The write-back command is handled by the controller itself.
  function automatic logic is_write(input logic [7:0] code);
    return code == {4'd0, WRITE};
  endfunction

endpackage

// File: rtl/lcd_wb_engine.sv
// Write-back engine: walks the datapath image read address over every pixel
// and copies each read word into the output buffer one cycle later.
`timescale 1ns/1ps
module lcd_wb_engine
  import lcd_seq_pkg::*;
#(
  parameter int BEATS = IMG_PIX
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_i,
  input  logic [7:0] rd_data_i,
  output logic [5:0] rd_addr_o,
  output logic       irb_we_o,
  output logic [5:0] irb_a_o,
  output logic [7:0] irb_d_o,
  output logic       last_o
);

  localparam logic [5:0] LAST_BEAT = 6'(BEATS - 1);

  logic       active_q, active_d;
  logic [5:0] cnt_q, cnt_d;
  logic       irb_we_q;
  logic [5:0] irb_a_q;
  logic [7:0] irb_d_q;

  // Beat counter: armed by start, runs once over all beats, rests at zero.
  always_comb begin
    active_d = active_q;
    cnt_d    = cnt_q;
    if (start_i) begin
      active_d = 1'b1;
      cnt_d    = 6'd0;
    end else if (active_q) begin
      if (cnt_q == LAST_BEAT) begin
        active_d = 1'b0;
        cnt_d    = 6'd0;
      end else begin
        cnt_d = cnt_q + 6'd1;
      end
    end else begin
      active_d = 1'b0;
      cnt_d    = 6'd0;
    end
  end

  // Counter state and the registered output-buffer write port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      active_q <= 1'b0;
      cnt_q    <= 6'd0;
      irb_we_q <= 1'b0;
      irb_a_q  <= 6'd0;
      irb_d_q  <= 8'd0;
    end else begin
      active_q <= active_d;
      cnt_q    <= cnt_d;
      irb_we_q <= active_q;
      if (active_q) begin
        irb_a_q <= cnt_q;
        irb_d_q <= rd_data_i;
      end
    end
  end

  // The counter sits at zero whenever the engine is idle.
  assign rd_addr_o = active_q ? cnt_q : 6'd0;
  assign irb_we_o  = irb_we_q;
  assign irb_a_o   = irb_a_q;
  assign irb_d_o   = irb_d_q;
  assign last_o    = irb_we_q && (irb_a_q == LAST_BEAT);

endmodule

// File: rtl/lcd_seq_ctrl.sv
// LCD sequencing controller: loads an image from ROM into the datapath,
// plays the command list that follows it, then writes the result back.
`timescale 1ns/1ps
module lcd_seq_ctrl
  import lcd_seq_pkg::*;
#(
  parameter int IMG_PIX  = lcd_seq_pkg::IMG_PIX,
  parameter int CMD_BASE = lcd_seq_pkg::CMD_BASE,
  parameter int ROM_LAST = lcd_seq_pkg::ROM_LAST
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       rom_en,
  output logic [6:0] rom_a,
  input  logic [7:0] rom_q,
  output logic       ld_valid,
  output logic [5:0] ld_addr,
  output logic [7:0] ld_data,
  output logic       cmd_valid,
  output logic [3:0] cmd_code,
  input  logic       cmd_ready,
  output logic [5:0] rd_addr,
  input  logic [7:0] rd_data,
  output logic       irb_we,
  output logic [5:0] irb_a,
  output logic [7:0] irb_d,
  output logic       busy,
  output logic       done,
  output logic [6:0] cmd_cnt
);

  localparam logic [6:0] LOAD_END  = 7'(IMG_PIX);
  localparam logic [6:0] CMD_START = 7'(CMD_BASE);
  localparam logic [6:0] PTR_LAST  = 7'(ROM_LAST);

  state_e     state_q, state_d;
  logic [6:0] ptr_q, ptr_d;       // load address in LOAD, command pointer after
  logic [7:0] code_q, code_d;     // command byte captured on ISSUE entry
  logic       have_q, have_d;     // code_q holds the current command
  logic [6:0] cnt_q, cnt_d;
  logic       ld_valid_q;
  logic [5:0] ld_addr_q;

  logic       rom_en_s;
  logic [6:0] rom_a_s;
  logic       cmd_val_s;
  logic       adv_s;
  logic       wb_start_s;
  logic       wb_last_s;

  // Next-state, pointer and command decode for the job sequencer.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    code_d     = code_q;
    have_d     = have_q;
    cnt_d      = cnt_q;
    rom_en_s   = 1'b0;
    rom_a_s    = 7'd0;
    cmd_val_s  = 1'b0;
    adv_s      = 1'b0;
    wb_start_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_LOAD;
          ptr_d   = 7'd0;
          cnt_d   = 7'd0;
          have_d  = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        // Reads run while the pointer is inside the image; one extra cycle
        // lets the final pixel strobe out before the command phase.
        if (ptr_q < LOAD_END) begin
          rom_en_s = 1'b1;
          rom_a_s  = ptr_q;
          ptr_d    = ptr_q + 7'd1;
        end else begin
          state_d = ST_FETCH;
          ptr_d   = CMD_START;
        end
      end
      ST_FETCH: begin
        rom_en_s = 1'b1;
        rom_a_s  = ptr_q;
        have_d   = 1'b0;
        state_d  = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (!have_q) begin
          code_d = rom_q;
          have_d = 1'b1;
        end else if (is_write(code_q)) begin
          have_d     = 1'b0;
          state_d    = ST_WRITE;
          wb_start_s = 1'b1;
        end else if (is_nop(code_q)) begin
          have_d = 1'b0;
          adv_s  = 1'b1;
        end else begin
          cmd_val_s = 1'b1;
          if (cmd_ready) begin
            have_d = 1'b0;
            adv_s  = 1'b1;
            cnt_d  = (cnt_q == 7'd127) ? cnt_q : cnt_q + 7'd1;
          end else begin
            have_d = 1'b1;
          end
        end
        // The last ROM entry ends the command list instead of wrapping.
        if (adv_s) begin
          if (ptr_q == PTR_LAST) begin
            state_d    = ST_WRITE;
            wb_start_s = 1'b1;
          end else begin
            ptr_d   = ptr_q + 7'd1;
            state_d = ST_FETCH;
          end
        end else begin
          ptr_d = ptr_q;
        end
      end
      ST_WRITE: begin
        if (wb_last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state, pointer, command capture and accepted-command count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= 7'd0;
      code_q  <= 8'd0;
      have_q  <= 1'b0;
      cnt_q   <= 7'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      code_q  <= code_d;
      have_q  <= have_d;
      cnt_q   <= cnt_d;
    end
  end

  // Pixel strobe follows each image read by one cycle, when ROM data lands.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ld_valid_q <= 1'b0;
      ld_addr_q  <= 6'd0;
    end else begin
      ld_valid_q <= rom_en_s && (state_q == ST_LOAD);
      if (rom_en_s && (state_q == ST_LOAD)) begin
        ld_addr_q <= ptr_q[5:0];
      end
    end
  end

  lcd_wb_engine #(
    .BEATS(IMG_PIX)
  ) u_wb (
    .clk      (clk),
    .reset    (reset),
    .start_i  (wb_start_s),
    .rd_data_i(rd_data),
    .rd_addr_o(rd_addr),
    .irb_we_o (irb_we),
    .irb_a_o  (irb_a),
    .irb_d_o  (irb_d),
    .last_o   (wb_last_s)
  );

  assign rom_en    = rom_en_s;
  assign rom_a     = rom_a_s;
  assign ld_valid  = ld_valid_q;
  assign ld_addr   = ld_addr_q;
  assign ld_data   = ld_valid_q ? rom_q : 8'd0;
  assign cmd_valid = cmd_val_s;
  assign cmd_code  = cmd_val_s ? code_q[3:0] : 4'd0;
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign cmd_cnt   = cnt_q;

endmodule

// File: tb/tb_lcd_seq_ctrl.sv
// Self-checking bench for lcd_seq_ctrl: a ROM model, an inverting read-data
// datapath and a scoreboard of expected pixel loads, commands and writes.
`timescale 1ns/1ps
module tb_lcd_seq_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic       rom_en;
  logic [6:0] rom_a;
  logic [7:0] rom_q;
  logic       ld_valid;
  logic [5:0] ld_addr;
  logic [7:0] ld_data;
  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic       cmd_ready;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       irb_we;
  logic [5:0] irb_a;
  logic [7:0] irb_d;
  logic       busy;
  logic       done;
  logic [6:0] cmd_cnt;

  logic [7:0]  rom_mem [0:127];
  logic [13:0] exp_ld[$];
  logic [3:0]  exp_cmd[$];
  logic [13:0] exp_irb[$];

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt, exp_fetch, exp_last;
  int dones, max_run, fetch_cnt, last_fetch;
  bit aborted;

  lcd_seq_ctrl dut (
    .clk(clk), .reset(reset), .start(start),
    .rom_en(rom_en), .rom_a(rom_a), .rom_q(rom_q),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_ready(cmd_ready),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .irb_we(irb_we), .irb_a(irb_a), .irb_d(irb_d),
    .busy(busy), .done(done), .cmd_cnt(cmd_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model with one cycle of read latency.
  always @(posedge clk) begin
    if (rom_en) rom_q <= rom_mem[rom_a];
  end

  // Datapath image: each pixel reads back as the inverse of its address.
  assign rd_data = ~{2'b00, rd_addr};

  // Reference model: expected loads, commands and writes for the ROM image.
  task automatic build_exp();
    bit fin;
    exp_ld.delete(); exp_cmd.delete(); exp_irb.delete();
    for (int i = 0; i < 64; i++) exp_ld.push_back({i[5:0], rom_mem[i]});
    exp_cnt = 0; exp_fetch = 0; exp_last = 0; fin = 1'b0;
    for (int p = 64; p < 128 && !fin; p++) begin
      exp_fetch++;
      exp_last = p;
      if (rom_mem[p] == 8'd8) fin = 1'b1;
      else if (rom_mem[p] != 8'd0 && rom_mem[p] < 8'd15) begin
        exp_cmd.push_back(rom_mem[p][3:0]);
        exp_cnt++;
      end
    end
    for (int i = 0; i < 64; i++) exp_irb.push_back({i[5:0], ~{2'b00, i[5:0]}});
  endtask

  // Runs one job from a start pulse, scoring every DUT output event.
  task automatic run_job(input int ready_delay, input int abort_irb, input bit poke_start);
    int run, load_idx;
    bit seen_done, poked, stop;
    logic [3:0]  held;
    logic [13:0] e;
    dones = 0; max_run = 0; fetch_cnt = 0; last_fetch = 0; aborted = 1'b0;
    run = 0; load_idx = 0; seen_done = 1'b0; poked = 1'b0; stop = 1'b0; held = 4'd0;
    start = 1'b1;
    @(negedge clk);
    for (int cyc = 0; cyc < 4000 && !stop; cyc++) begin
      start = 1'b0;
      if (seen_done) begin
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
          n_fail++; $display("FAIL idle_after_done: busy=%b done=%b, required 0 0", busy, done);
        end
        stop = 1'b1;
      end else begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++; $display("FAIL busy_in_job: busy=%b, required 1 (cycle %0d)", busy, cyc);
        end
        n_checks++;
        if (({2'b00, ld_valid} + {2'b00, cmd_valid} + {2'b00, irb_we}) > 3'd1) begin
          n_fail++; $display("FAIL exclusive: ld=%b cmd=%b we=%b, required at most one", ld_valid, cmd_valid, irb_we);
        end
        if (rom_en) begin
          if (rom_a < 7'd64) begin
            n_checks++;
            if (rom_a !== load_idx[6:0]) begin
              n_fail++; $display("FAIL load_rom_a: got %0d, required %0d", rom_a, load_idx);
            end
            load_idx++;
          end else begin
            fetch_cnt++;
            last_fetch = int'(rom_a);
          end
        end
        if (ld_valid) begin
          n_checks++;
          if (exp_ld.size() == 0) begin
            n_fail++; $display("FAIL ld_extra: addr=%0d data=%0d, required no strobe", ld_addr, ld_data);
          end else begin
            e = exp_ld.pop_front();
            if ({ld_addr, ld_data} !== e) begin
              n_fail++; $display("FAIL ld_beat: addr/data %0d/%0d, required %0d/%0d", ld_addr, ld_data, e[13:8], e[7:0]);
            end
          end
        end
        if (cmd_valid) begin
          run++;
          if (run == 1) held = cmd_code;
          else begin
            n_checks++;
            if (cmd_code !== held) begin
              n_fail++; $display("FAIL cmd_stable: code=%0d, required %0d", cmd_code, held);
            end
          end
          if (run > max_run) max_run = run;
          cmd_ready = (run > ready_delay);
          if (poke_start && !poked) begin
            start = 1'b1;
            poked = 1'b1;
          end
          if (cmd_ready) begin
            n_checks++;
            if (exp_cmd.size() == 0) begin
              n_fail++; $display("FAIL cmd_extra: code=%0d, required no command", cmd_code);
            end else if (cmd_code !== exp_cmd[0]) begin
              n_fail++; $display("FAIL cmd_code: got %0d, required %0d", cmd_code, exp_cmd[0]);
              void'(exp_cmd.pop_front());
            end else begin
              void'(exp_cmd.pop_front());
            end
          end
        end else begin
          run = 0;
          cmd_ready = 1'b1;
        end
        if (irb_we) begin
          n_checks++;
          if (exp_irb.size() == 0) begin
            n_fail++; $display("FAIL irb_extra: a=%0d d=%0d, required no write", irb_a, irb_d);
          end else begin
            e = exp_irb.pop_front();
            if ({irb_a, irb_d} !== e) begin
              n_fail++; $display("FAIL irb_beat: a/d %0d/%0d, required %0d/%0d", irb_a, irb_d, e[13:8], e[7:0]);
            end
          end
          if (abort_irb >= 0 && irb_a == abort_irb[5:0]) begin
            aborted = 1'b1;
            stop = 1'b1;
          end
        end
        if (done) begin
          dones++;
          seen_done = 1'b1;
        end
      end
      if (!stop) @(negedge clk);
    end
    cmd_ready = 1'b1;
    start = 1'b0;
    n_checks++;
    if (!stop) begin
      n_fail++; $display("FAIL job_timeout: job still running after 4000 cycles, required done");
    end
    if (!aborted) begin
      n_checks++;
      if (exp_ld.size() + exp_cmd.size() + exp_irb.size() != 0) begin
        n_fail++; $display("FAIL scoreboard_drain: ld=%0d cmd=%0d irb=%0d left, required 0 0 0",
                           exp_ld.size(), exp_cmd.size(), exp_irb.size());
      end
    end
  endtask

  task automatic test_reset();
    logic [57:0] outs;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    outs = {rom_en, rom_a, ld_valid, ld_addr, ld_data, cmd_valid, cmd_code,
            rd_addr, irb_we, irb_a, irb_d, busy, done, cmd_cnt};
    n_checks++;
    if (outs !== 58'd0) begin
      n_fail++; $display("FAIL reset_outputs: got %h, required 0", outs);
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL idle_after_reset: busy=%b, required 0", busy);
    end
  endtask

  // Incrementing image, one command held off by five cycles, then Write.
  task automatic test_load_handshake();
    for (int i = 0; i < 128; i++) rom_mem[i] = 8'd0;
    for (int i = 0; i < 64; i++) rom_mem[i] = 8'(i + 3);
    rom_mem[64] = 8'd4;
    rom_mem[65] = 8'd8;
    build_exp();
    run_job(5, -1, 1'b0);
    n_checks++;
    if (max_run != 6) begin
      n_fail++; $display("FAIL hs_hold: cmd_valid held %0d cycles, required 6", max_run);
    end
    n_checks++;
    if (cmd_cnt !== 7'd1) begin
      n_fail++; $display("FAIL hs_cmd_cnt: got %0d, required 1", cmd_cnt);
    end
    n_checks++;
    if (fetch_cnt != 2 || dones != 1) begin
      n_fail++; $display("FAIL hs_flow: fetches=%0d dones=%0d, required 2 1", fetch_cnt, dones);
    end
  endtask

  // All-NOP command area: the pointer must walk to the last entry.
  task automatic test_nop_end();
    for (int i = 64; i < 128; i++) rom_mem[i] = 8'd0;
    build_exp();
    run_job(0, -1, 1'b0);
    n_checks++;
    if (cmd_cnt !== 7'd0 || fetch_cnt != 64 || last_fetch != 127) begin
      n_fail++; $display("FAIL nop_end: cnt=%0d fetches=%0d last=%0d, required 0 64 127",
                         cmd_cnt, fetch_cnt, last_fetch);
    end
    n_checks++;
    if (dones != 1) begin
      n_fail++; $display("FAIL nop_done: dones=%0d, required 1", dones);
    end
  endtask

  // Random image and command mix, then a second job immediately after.
  task automatic test_back_to_back();
    int r;
    for (int i = 0; i < 64; i++) rom_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 64; i < 128; i++) begin
      r = $urandom_range(0, 3);
      if (r == 0) rom_mem[i] = 8'($urandom_range(15, 255));
      else if (r == 1) rom_mem[i] = 8'd0;
      else begin
        rom_mem[i] = 8'($urandom_range(1, 14));
        if (rom_mem[i] == 8'd8) rom_mem[i] = 8'd9;
      end
    end
    rom_mem[127] = 8'd5;
    build_exp();
    run_job(2, -1, 1'b0);
    n_checks++;
    if (cmd_cnt !== exp_cnt[6:0] || fetch_cnt != exp_fetch || last_fetch != exp_last) begin
      n_fail++; $display("FAIL mix_a: cnt=%0d fetches=%0d last=%0d, required %0d %0d %0d",
                         cmd_cnt, fetch_cnt, last_fetch, exp_cnt, exp_fetch, exp_last);
    end
    rom_mem[100] = 8'd8;
    build_exp();
    run_job(0, -1, 1'b0);
    n_checks++;
    if (cmd_cnt !== exp_cnt[6:0] || fetch_cnt != exp_fetch || dones != 1) begin
      n_fail++; $display("FAIL mix_b: cnt=%0d fetches=%0d dones=%0d, required %0d %0d 1",
                         cmd_cnt, fetch_cnt, dones, exp_cnt, exp_fetch);
    end
  endtask

  // A start pulse while a command is offered must not spawn a second job.
  task automatic test_start_in_issue();
    for (int i = 64; i < 128; i++) rom_mem[i] = 8'd0;
    rom_mem[64] = 8'd11;
    rom_mem[66] = 8'd2;
    rom_mem[67] = 8'd8;
    build_exp();
    run_job(3, -1, 1'b1);
    n_checks++;
    if (dones != 1 || cmd_cnt !== 7'd2) begin
      n_fail++; $display("FAIL start_ignored: dones=%0d cnt=%0d, required 1 2", dones, cmd_cnt);
    end
    repeat (4) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        n_fail++; $display("FAIL stay_idle: busy=%b done=%b, required 0 0", busy, done);
      end
    end
  endtask

  // Reset at write beat 20 kills the job; a fresh start replays it fully.
  task automatic test_reset_mid_write();
    for (int i = 64; i < 128; i++) rom_mem[i] = 8'd0;
    rom_mem[64] = 8'd1;
    rom_mem[65] = 8'd14;
    rom_mem[70] = 8'd8;
    build_exp();
    run_job(1, 20, 1'b0);
    n_checks++;
    if (!aborted || cmd_cnt !== 7'd2) begin
      n_fail++; $display("FAIL pre_abort: aborted=%b cnt=%0d, required 1 2", aborted, cmd_cnt);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({irb_we, busy, done, cmd_cnt, rd_addr} !== 16'd0) begin
      n_fail++; $display("FAIL abort_async: we=%b busy=%b cnt=%0d rd=%0d, required all 0",
                         irb_we, busy, cmd_cnt, rd_addr);
    end
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (irb_we !== 1'b0) begin
      n_fail++; $display("FAIL abort_we: irb_we=%b, required 0", irb_we);
    end
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || irb_we !== 1'b0 || rom_en !== 1'b0) begin
        n_fail++; $display("FAIL no_resume: busy=%b we=%b rom_en=%b, required 0 0 0", busy, irb_we, rom_en);
      end
    end
    build_exp();
    run_job(0, -1, 1'b0);
    n_checks++;
    if (dones != 1 || cmd_cnt !== 7'd2) begin
      n_fail++; $display("FAIL replay: dones=%0d cnt=%0d, required 1 2", dones, cmd_cnt);
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cmd_ready = 1'b1;
    rom_q = 8'd0;
    for (int i = 0; i < 128; i++) rom_mem[i] = 8'd0;
    test_reset();
    test_load_handshake();
    test_nop_end();
    test_back_to_back();
    test_start_in_issue();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
